mov_fsm: RTL and testbench

- Parametrised move-instruction controller for the microcontroller datapath.
- Executes MOVi (immediate to register) and MOV (register to register) from one 16-bit instruction word.
- Drives the register-file load/enable one-hot strobes, the immediate tri-state bus driver, the PC increment and completion flags.
- Replaces the single-mode, fixed-width move FSM. Adds register-to-register mode, configurable register count and data width, and illegal-register detection.

---
 rtl/mov_fsm_if.sv | 21 ++
 rtl/mov_fsm.sv | 87 ++++++++
 tb/tb_mov_fsm.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mov_fsm_if.sv
// mov_fsm_if: instruction/strobe bundle between the sequencer and the move controller
//   instruction : 16-bit instruction word into the controller
//   done/err    : completion pulse and illegal-register flag
//   pcInc/triEN : PC increment strobe, immediate bus driver enable
//   rxIn/rxOut  : one-hot register load / output enable, register k on bit NREG-1-k
//   param2Out   : extended immediate
interface mov_fsm_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 6
);
    logic [15:0]       instruction;
    logic              done;
    logic              err;
    logic              pcInc;
    logic              triEN;
    logic [NREG-1:0]   rxIn;
    logic [NREG-1:0]   rxOut;
    logic [DATA_W-1:0] param2Out;
    modport master (output instruction, input done, err, pcInc, triEN, rxIn, rxOut, param2Out);
    modport slave  (input instruction, output done, err, pcInc, triEN, rxIn, rxOut, param2Out);
endinterface

// File: rtl/mov_fsm.sv
// mov_fsm: MOVi/MOV move-instruction controller with register-index checking
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mov_fsm_if slave (instruction in; done, err, pcInc, triEN, rxIn, rxOut, param2Out out)
//   MOVI_SEXT_EN : when defined, the MOVi immediate is sign-extended instead of zero-extended
module mov_fsm #(
    parameter int          DATA_W   = 16,
    parameter int          NREG     = 6,
    parameter logic [3:0]  OPC_MOVI = 4'b0101,
    parameter logic [3:0]  OPC_MOV  = 4'b0100
) (
    input  logic      clk,
    input  logic      rst,
    mov_fsm_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, WRITE, DONE, HOLD} state_t;

    // Register k is bit NREG-1-k: shifting the MSB right by the index yields
    // the one-hot, and an index >= NREG shifts it out to all-zero.
    localparam logic [NREG-1:0] MSB = NREG'(1) << (NREG - 1);

    state_t            state_q, state_d;
    logic              movi_q, movi_d;
    logic [5:0]        p1_q, p1_d, p2_q, p2_d;
    logic [3:0]        opc;
    logic              match, keep, xfer, bad1, bad2;
    logic [NREG-1:0]   sel1, sel2;
    logic [DATA_W-1:0] ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            movi_q  <= 1'b0;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            movi_q  <= movi_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end

    always_comb begin
        opc     = bus.instruction[15:12];
        match   = opc == OPC_MOVI || opc == OPC_MOV;
        keep    = opc == (movi_q ? OPC_MOVI : OPC_MOV);
        state_d = state_q;
        movi_d  = movi_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        case (state_q)
            IDLE: if (match) begin
                state_d = DRIVE;
                movi_d  = opc == OPC_MOVI;
                p1_d    = bus.instruction[11:6];
                p2_d    = bus.instruction[5:0];
            end
            DRIVE:   state_d = keep ? WRITE : IDLE;
            WRITE:   state_d = keep ? DONE : IDLE;
            DONE:    state_d = keep ? HOLD : IDLE;
            HOLD:    state_d = match ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MOVI_SEXT_EN
    assign ext = DATA_W'($signed(p2_q));
`else
    assign ext = DATA_W'(p2_q);
`endif

    assign sel1 = MSB >> p1_q;
    assign sel2 = MSB >> p2_q;
    assign bad1 = ~|sel1;
    // An illegal MOV source also suppresses the load, so nothing is written.
    assign bad2 = ~movi_q & ~|sel2;
    assign xfer = state_q == DRIVE || state_q == WRITE;

    assign bus.pcInc     = state_q == DRIVE;
    assign bus.triEN     = xfer & movi_q;
    assign bus.param2Out = (xfer & movi_q) ? ext : '0;
    assign bus.rxOut     = (xfer & ~movi_q) ? sel2 : '0;
    assign bus.rxIn      = (state_q == WRITE && !bad2) ? sel1 : '0;
    assign bus.done      = state_q == DONE;
    assign bus.err       = state_q == DONE && (bad1 || bad2);
endmodule

// File: tb/tb_mov_fsm.sv
// tb_mov_fsm: self-checking bench for mov_fsm with directed scenarios and a randomized scoreboard
module tb_mov_fsm;
    localparam int DW = 16;
    localparam int NR = 6;
    localparam int PW = 4 + 2 * NR + DW;
    typedef logic [PW-1:0] vec_t;

    localparam logic [15:0] MOVI_R2_37 = 16'b0101_000010_100101;
    localparam logic [15:0] MOV_R5_R1  = 16'b0100_000101_000001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    mov_fsm_if #(.DATA_W(DW), .NREG(NR)) b();
    mov_fsm #(.DATA_W(DW), .NREG(NR)) dut (.clk(clk), .rst(rst), .bus(b.slave));

    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {b.done, b.err, b.pcInc, b.triEN, b.rxIn, b.rxOut, b.param2Out};
    endfunction

    function automatic vec_t pack(bit dn, bit er, bit pc, bit tr, logic [NR-1:0] ri, logic [NR-1:0] ro, logic [DW-1:0] po);
        return {dn, er, pc, tr, ri, ro, po};
    endfunction

    function automatic logic [NR-1:0] oh(int k);
        logic [NR-1:0] v = '0;
        v[NR-1-k] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] imm(int v);
`ifdef MOVI_SEXT_EN
        return DW'(v >= 32 ? v - 64 : v);
`else
        return DW'(v);
`endif
    endfunction

    // Expected outputs for phase 1 (first cycle after accept), 2, 3; anything else is quiet.
    function automatic vec_t model(logic [15:0] ins, int ph);
        int p1 = int'(ins[11:6]);
        int p2 = int'(ins[5:0]);
        bit movi = ins[15:12] == 4'b0101;
        bit ok1 = p1 < NR;
        bit ok2 = movi || p2 < NR;
        logic [NR-1:0] src = (!movi && ok2) ? oh(p2) : '0;
        logic [NR-1:0] dst = (ok1 && ok2) ? oh(p1) : '0;
        logic [DW-1:0] im = movi ? imm(p2) : '0;
        case (ph)
            1:       return pack(0, 0, 1, movi, '0, src, im);
            2:       return pack(0, 0, 0, movi, dst, src, im);
            3:       return pack(1, !(ok1 && ok2), 0, 0, '0, '0, '0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] nonmatch();
        logic [3:0] o = 4'($urandom_range(0, 15));
        return (o == 4'b0101 || o == 4'b0100) ? o ^ 4'b1000 : o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t got;
        vec_t exp;
        rst = 1'b0;
        b.instruction = MOVI_R2_37;
        for (int i = 0; i < 2; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, '0);
            end
        end
        rst = 1'b1;
        step();
        exp = pack(0, 0, 1, 1, '0, '0, 16'h0025);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", got, exp);
        end
        b.instruction = '0;
        step();
        step();
    endtask

    task automatic test_movi();
        vec_t got;
        vec_t e[5];
        e = '{pack(0, 0, 1, 1, '0, '0, 16'h0025),
              pack(0, 0, 0, 1, 6'b001000, '0, 16'h0025),
              pack(1, 0, 0, 0, '0, '0, '0), '0, '0};
        b.instruction = MOVI_R2_37;
        for (int i = 0; i < 5; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== e[i]) begin
                miscompares++;
                $display("FAIL movi cyc=%0d got=%h exp=%h", i, got, e[i]);
            end
        end
        b.instruction = '0;
        step();
    endtask

    task automatic test_mov();
        vec_t got;
        vec_t e[4];
        e = '{pack(0, 0, 1, 0, '0, 6'b010000, '0),
              pack(0, 0, 0, 0, 6'b000001, 6'b010000, '0),
              pack(1, 0, 0, 0, '0, '0, '0), '0};
        b.instruction = MOV_R5_R1;
        for (int i = 0; i < 4; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== e[i]) begin
                miscompares++;
                $display("FAIL mov cyc=%0d got=%h exp=%h", i, got, e[i]);
            end
        end
        b.instruction = '0;
        step();
    endtask

    task automatic test_illegal();
        vec_t got;
        vec_t e[2][4];
        logic [15:0] ins[2];
        ins = '{{4'b0101, 6'd7, 6'd5}, {4'b0100, 6'd2, 6'd9}};
        e[0] = '{pack(0, 0, 1, 1, '0, '0, 16'h0005), pack(0, 0, 0, 1, '0, '0, 16'h0005),
                 pack(1, 1, 0, 0, '0, '0, '0), '0};
        e[1] = '{pack(0, 0, 1, 0, '0, '0, '0), '0, pack(1, 1, 0, 0, '0, '0, '0), '0};
        for (int t = 0; t < 2; t++) begin
            b.instruction = ins[t];
            for (int i = 0; i < 4; i++) begin
                step();
                got = obs();
                vectors++;
                if (got !== e[t][i]) begin
                    miscompares++;
                    $display("FAIL illegal t=%0d cyc=%0d got=%h exp=%h", t, i, got, e[t][i]);
                end
            end
            b.instruction = '0;
            step();
        end
    endtask

    task automatic test_abort();
        vec_t got;
        vec_t exp;
        b.instruction = MOVI_R2_37;
        step();
        step();
        exp = pack(0, 0, 0, 1, 6'b001000, '0, 16'h0025);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL abort_write got=%h exp=%h", got, exp);
        end
        b.instruction = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL abort_quiet cyc=%0d got=%h exp=%h", i, got, '0);
            end
        end
        // switching to the other move opcode aborts, then restarts as a fresh MOV
        b.instruction = MOVI_R2_37;
        step();
        b.instruction = MOV_R5_R1;
        step();
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL abort_switch got=%h exp=%h", got, '0);
        end
        step();
        exp = pack(0, 0, 1, 0, '0, 6'b010000, '0);
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL abort_restart got=%h exp=%h", got, exp);
        end
        b.instruction = '0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        vec_t got;
        b.instruction = MOVI_R2_37;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=%h", got, '0);
        end
        b.instruction = '0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL async_after cyc=%0d got=%h exp=%h", i, got, '0);
            end
        end
    endtask

    task automatic test_extension();
        vec_t got;
        vec_t exp;
`ifdef MOVI_SEXT_EN
        exp = pack(0, 0, 1, 1, '0, '0, 16'hFFFF);
`else
        exp = pack(0, 0, 1, 1, '0, '0, 16'h003F);
`endif
        b.instruction = {4'b0101, 6'd0, 6'b111111};
        step();
        got = obs();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL extension got=%h exp=%h", got, exp);
        end
        b.instruction = '0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        vec_t got;
        vec_t exp;
        b.instruction = MOVI_R2_37;
        for (int ph = 1; ph <= 4; ph++) begin
            step();
            exp = model(MOVI_R2_37, ph);
            got = obs();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_movi ph=%0d got=%h exp=%h", ph, got, exp);
            end
        end
        b.instruction = MOV_R5_R1;
        for (int i = 0; i < 2; i++) begin
            step();
            got = obs();
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL b2b_hold cyc=%0d got=%h exp=%h", i, got, '0);
            end
        end
        b.instruction = '0;
        step();
        b.instruction = MOV_R5_R1;
        for (int ph = 1; ph <= 4; ph++) begin
            step();
            exp = model(MOV_R5_R1, ph);
            got = obs();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b_mov ph=%0d got=%h exp=%h", ph, got, exp);
            end
        end
        b.instruction = '0;
        step();
    endtask

    task automatic test_random();
        vec_t got;
        vec_t exp;
        logic [15:0] ins;
        logic [3:0] opc;
        int sel, p1, p2, abort;
        bit aborted;
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 3);
            opc = sel == 0 ? 4'b0101 : sel == 1 ? 4'b0100 : sel == 2 ? 4'b0101 : nonmatch();
            p1 = $urandom_range(0, 1) ? $urandom_range(0, NR - 1) : $urandom_range(0, 63);
            p2 = $urandom_range(0, 1) ? $urandom_range(0, NR - 1) : $urandom_range(0, 63);
            ins = {opc, 6'(p1), 6'(p2)};
            abort = $urandom_range(0, 6);
            aborted = 1'b0;
            b.instruction = ins;
            if (opc != 4'b0101 && opc != 4'b0100) begin
                step();
                got = obs();
                vectors++;
                if (got !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_nomatch t=%0d ins=%h got=%h exp=%h", t, ins, got, '0);
                end
                continue;
            end
            for (int ph = 1; ph <= 4 && !aborted; ph++) begin
                step();
                exp = model(ins, ph);
                got = obs();
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL rnd t=%0d ins=%h ph=%0d got=%h exp=%h", t, ins, ph, got, exp);
                end
                if (ph == abort) begin
                    b.instruction = {nonmatch(), 12'($urandom)};
                    step();
                    got = obs();
                    vectors++;
                    if (got !== '0) begin
                        miscompares++;
                        $display("FAIL rnd_abort t=%0d ins=%h ph=%0d got=%h exp=%h", t, ins, ph, got, '0);
                    end
                    aborted = 1'b1;
                end else begin
                    b.instruction = {opc, 12'($urandom)};
                end
            end
            if (!aborted) begin
                b.instruction = {nonmatch(), 12'($urandom)};
                step();
                got = obs();
                vectors++;
                if (got !== '0) begin
                    miscompares++;
                    $display("FAIL rnd_release t=%0d ins=%h got=%h exp=%h", t, ins, got, '0);
                end
            end
        end
    endtask

    initial begin
        b.instruction = '0;
        test_reset();
        test_movi();
        test_mov();
        test_illegal();
        test_abort();
        test_async_reset();
        test_extension();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
